quarter_dispenser: RTL and testbench

Change-return side of the parking machine: accepts a refund request expressed as a number of quarters and drives the coin hopper solenoid once per quarter. It waits for the hopper's coin sensor to confirm each drop, and reports completion or a jam. It is the payout counterpart of the quarter-accepting ticket FSM and sits between the machine controller and the hopper hardware.

---
 rtl/parking_pkg.sv | 6 +
 rtl/dispense_timer.sv | 18 +
 rtl/quarter_dispenser.sv | 94 +++++++++
 tb/tb_quarter_dispenser.sv | 216 +++++++++++++++++++++
 4 files changed

// File: rtl/parking_pkg.sv
// parking_pkg: shared parking-machine types and constants
package parking_pkg;
    typedef enum logic [1:0] {IDLE, DRIVE, WAIT} dispense_state_t;
    localparam int QUARTER_CENTS = 25;
    localparam int MAX_QUARTERS_DEFAULT = 15;
endpackage

// File: rtl/dispense_timer.sv
// dispense_timer: loadable down-counter that flags expiry when it reaches zero
module dispense_timer #(
    parameter int W = 6
) (
    input  logic         clk,
    input  logic         reset_n,
    input  logic         load,
    input  logic [W-1:0] load_val,
    output logic         expired
);
    logic [W-1:0] count;
    always_ff @(posedge clk) begin
        if (!reset_n) count <= '0;
        else if (load) count <= load_val;
        else if (count != '0) count <= count - W'(1);
    end
    assign expired = count == '0;
endmodule

// File: rtl/quarter_dispenser.sv
// quarter_dispenser: pays out refunds one quarter at a time, confirming each drop on the coin sensor
module quarter_dispenser
    import parking_pkg::*;
#(
    parameter int MAX_QUARTERS = MAX_QUARTERS_DEFAULT,
    parameter int PULSE_CYCLES = 4,
    parameter int TIMEOUT_CYCLES = 64,
    localparam int CNT_W = $clog2(MAX_QUARTERS + 1)
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             req_valid,
    input  logic [CNT_W-1:0] req_count,
    output logic             req_ready,
    output logic             hopper_drive,
    input  logic             coin_sensed,
    output logic             busy,
    output logic             done,
    output logic             fault,
    output logic [CNT_W-1:0] remaining,
    output logic [CNT_W-1:0] dispensed
);
    localparam int TW = $clog2(TIMEOUT_CYCLES > PULSE_CYCLES ? TIMEOUT_CYCLES : PULSE_CYCLES);
    localparam logic [CNT_W:0] MAXQ = (CNT_W + 1)'(MAX_QUARTERS);
    dispense_state_t state;
    logic coin_flag, accept, coin_now, tmr_load, expired;
    logic [CNT_W-1:0] sat_count;
    logic [TW-1:0] tmr_val;
    assign req_ready = state == IDLE;
    assign busy = !req_ready;
    assign accept = req_valid && req_ready;
    assign sat_count = {1'b0, req_count} > MAXQ ? CNT_W'(MAX_QUARTERS) : req_count;
    assign coin_now = coin_sensed || coin_flag;
    // one timer serves both the drive width and the sensor timeout
    assign tmr_load = (accept && sat_count != '0) || (state == DRIVE && expired) ||
                      (state == WAIT && coin_now && remaining != CNT_W'(1));
    assign tmr_val = state == DRIVE ? TW'(TIMEOUT_CYCLES - 1) : TW'(PULSE_CYCLES - 1);
    dispense_timer #(.W(TW)) u_timer (
        .clk(clk),
        .reset_n(reset_n),
        .load(tmr_load),
        .load_val(tmr_val),
        .expired(expired)
    );
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state <= IDLE;
            hopper_drive <= 1'b0;
            done <= 1'b0;
            fault <= 1'b0;
            remaining <= '0;
            dispensed <= '0;
            coin_flag <= 1'b0;
        end else begin
            done <= 1'b0;
            fault <= 1'b0;
            unique case (state)
                IDLE: if (accept) begin
                    remaining <= sat_count;
                    dispensed <= '0;
                    coin_flag <= 1'b0;
                    if (sat_count == '0) done <= 1'b1;
                    else begin
                        hopper_drive <= 1'b1;
                        state <= DRIVE;
                    end
                end
                DRIVE: begin
                    if (coin_sensed) coin_flag <= 1'b1;
                    if (expired) begin
                        hopper_drive <= 1'b0;
                        state <= WAIT;
                    end
                end
                WAIT: if (coin_now) begin
                    remaining <= remaining - CNT_W'(1);
                    dispensed <= dispensed + CNT_W'(1);
                    coin_flag <= 1'b0;
                    if (remaining == CNT_W'(1)) begin
                        done <= 1'b1;
                        state <= IDLE;
                    end else begin
                        hopper_drive <= 1'b1;
                        state <= DRIVE;
                    end
                end else if (expired) begin
                    fault <= 1'b1;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_quarter_dispenser.sv
// tb_quarter_dispenser: directed self-checking bench for quarter_dispenser
module tb_quarter_dispenser;
    logic clk = 0, reset_n = 0, req_valid = 0, coin_sensed = 0;
    logic [3:0] req_count = 0;
    logic req_ready, hopper_drive, busy, done, fault;
    logic [3:0] remaining, dispensed;
    logic s_valid = 0, s_coin = 0;
    logic [3:0] s_count = 0;
    logic s_ready, s_drive, s_busy, s_done, s_fault;
    logic [3:0] s_remaining, s_dispensed;
    int n_cmp = 0, n_bad = 0;
    int cyc, rises, hi, dcnt, fcnt;
    logic to;

    quarter_dispenser dut (
        .clk(clk), .reset_n(reset_n), .req_valid(req_valid), .req_count(req_count),
        .req_ready(req_ready), .hopper_drive(hopper_drive), .coin_sensed(coin_sensed),
        .busy(busy), .done(done), .fault(fault), .remaining(remaining), .dispensed(dispensed)
    );

    quarter_dispenser #(.MAX_QUARTERS(10), .PULSE_CYCLES(1), .TIMEOUT_CYCLES(4)) sat_dut (
        .clk(clk), .reset_n(reset_n), .req_valid(s_valid), .req_count(s_count),
        .req_ready(s_ready), .hopper_drive(s_drive), .coin_sensed(s_coin),
        .busy(s_busy), .done(s_done), .fault(s_fault), .remaining(s_remaining), .dispensed(s_dispensed)
    );

    always #5 clk = ~clk;

    task step;
        @(posedge clk);
        #1;
    endtask

    // coin_delay: WAIT cycles before the sensor pulses (-1 = never); stops at done/fault or max_cyc
    task run(input int coin_delay, input int max_cyc);
        int wait_cnt;
        logic prev;
        wait_cnt = 0; prev = 0; cyc = 0; rises = 0; hi = 0; dcnt = 0; fcnt = 0; to = 1;
        for (int i = 0; i < max_cyc; i++) begin
            step;
            req_valid = 0;
            coin_sensed = 0;
            cyc++;
            if (hopper_drive && !prev) rises++;
            if (hopper_drive) hi++;
            prev = hopper_drive;
            if (done) dcnt++;
            if (fault) fcnt++;
            wait_cnt = (busy && !hopper_drive) ? wait_cnt + 1 : 0;
            if (coin_delay >= 0 && wait_cnt == coin_delay + 1) coin_sensed = 1;
            if (done || fault) begin
                to = 0;
                break;
            end
        end
    endtask

    task test_reset;
        reset_n = 0;
        repeat (3) step;
        n_cmp += 6;
        if (req_ready !== 1'b1) begin n_bad++; $display("FAIL reset_ready: got %b expected 1", req_ready); end
        if (hopper_drive !== 1'b0) begin n_bad++; $display("FAIL reset_drive: got %b expected 0", hopper_drive); end
        if (busy !== 1'b0) begin n_bad++; $display("FAIL reset_busy: got %b expected 0", busy); end
        if (done !== 1'b0 || fault !== 1'b0) begin n_bad++; $display("FAIL reset_pulses: got done=%b fault=%b expected 0 0", done, fault); end
        if (remaining !== 4'd0) begin n_bad++; $display("FAIL reset_remaining: got %0d expected 0", remaining); end
        if (dispensed !== 4'd0) begin n_bad++; $display("FAIL reset_dispensed: got %0d expected 0", dispensed); end
        reset_n = 1;
        step;
    endtask

    task test_normal;
        req_valid = 1; req_count = 4'd3;
        run(2, 100);
        n_cmp += 6;
        if (to || cyc != 22) begin n_bad++; $display("FAIL normal_cycles: got %0d expected 22", cyc); end
        if (rises != 3 || hi != 12) begin n_bad++; $display("FAIL normal_pulses: got %0d/%0d expected 3/12", rises, hi); end
        if (dcnt != 1 || fcnt != 0) begin n_bad++; $display("FAIL normal_done: got done=%0d fault=%0d expected 1 0", dcnt, fcnt); end
        if (remaining !== 4'd0) begin n_bad++; $display("FAIL normal_remaining: got %0d expected 0", remaining); end
        if (dispensed !== 4'd3) begin n_bad++; $display("FAIL normal_dispensed: got %0d expected 3", dispensed); end
        if (req_ready !== 1'b1) begin n_bad++; $display("FAIL normal_ready: got %b expected 1", req_ready); end
    endtask

    task test_timeout;
        req_valid = 1; req_count = 4'd2;
        run(-1, 100);
        n_cmp += 5;
        if (to || cyc != 69) begin n_bad++; $display("FAIL timeout_cycles: got %0d expected 69", cyc); end
        if (rises != 1 || fcnt != 1 || dcnt != 0) begin n_bad++; $display("FAIL timeout_pulses: got rises=%0d fault=%0d done=%0d expected 1 1 0", rises, fcnt, dcnt); end
        if (remaining !== 4'd2) begin n_bad++; $display("FAIL timeout_remaining: got %0d expected 2", remaining); end
        if (dispensed !== 4'd0) begin n_bad++; $display("FAIL timeout_dispensed: got %0d expected 0", dispensed); end
        step;
        if (req_ready !== 1'b1 || fault !== 1'b0) begin n_bad++; $display("FAIL timeout_after: got ready=%b fault=%b expected 1 0", req_ready, fault); end
    endtask

    task test_last_cycle_coin;
        req_valid = 1; req_count = 4'd1;
        run(63, 100);
        n_cmp += 2;
        if (to || cyc != 69 || dcnt != 1) begin n_bad++; $display("FAIL lastcoin_done: got cyc=%0d done=%0d expected 69 1", cyc, dcnt); end
        if (fcnt != 0 || dispensed !== 4'd1) begin n_bad++; $display("FAIL lastcoin_fault: got fault=%0d disp=%0d expected 0 1", fcnt, dispensed); end
    endtask

    task test_span;
        int at;
        logic prev;
        at = 0; prev = 0; rises = 0; dcnt = 0; fcnt = 0;
        req_valid = 1; req_count = 4'd1;
        for (int i = 1; i <= 14; i++) begin
            step;
            req_valid = 0;
            coin_sensed = (i >= 2 && i <= 11);
            if (hopper_drive && !prev) rises++;
            prev = hopper_drive;
            if (done) begin dcnt++; at = i; end
            if (fault) fcnt++;
        end
        coin_sensed = 0;
        n_cmp += 3;
        if (dcnt != 1 || at != 6) begin n_bad++; $display("FAIL span_done: got count=%0d at=%0d expected 1 6", dcnt, at); end
        if (rises != 1 || fcnt != 0) begin n_bad++; $display("FAIL span_pulses: got rises=%0d fault=%0d expected 1 0", rises, fcnt); end
        if (dispensed !== 4'd1 || remaining !== 4'd0) begin n_bad++; $display("FAIL span_counts: got disp=%0d rem=%0d expected 1 0", dispensed, remaining); end
    endtask

    task test_reset_mid;
        req_valid = 1; req_count = 4'd4;
        run(2, 9);
        n_cmp += 4;
        if (!to || hopper_drive !== 1'b1 || dispensed !== 4'd1) begin n_bad++; $display("FAIL mid_precond: got drive=%b disp=%0d expected 1 1", hopper_drive, dispensed); end
        reset_n = 0;
        step;
        if (hopper_drive !== 1'b0 || req_ready !== 1'b1) begin n_bad++; $display("FAIL mid_drive: got drive=%b ready=%b expected 0 1", hopper_drive, req_ready); end
        if (remaining !== 4'd0 || dispensed !== 4'd0) begin n_bad++; $display("FAIL mid_counts: got rem=%0d disp=%0d expected 0 0", remaining, dispensed); end
        reset_n = 1;
        dcnt = 0;
        for (int i = 0; i < 10; i++) begin
            if (done || fault) dcnt++;
            step;
        end
        if (dcnt != 0) begin n_bad++; $display("FAIL mid_pulses: got %0d expected 0", dcnt); end
    endtask

    task test_zero;
        req_valid = 1; req_count = 4'd0;
        step;
        req_valid = 0;
        n_cmp += 2;
        if (done !== 1'b1 || hopper_drive !== 1'b0 || busy !== 1'b0) begin n_bad++; $display("FAIL zero_done: got done=%b drive=%b busy=%b expected 1 0 0", done, hopper_drive, busy); end
        step;
        if (done !== 1'b0 || hopper_drive !== 1'b0) begin n_bad++; $display("FAIL zero_after: got done=%b drive=%b expected 0 0", done, hopper_drive); end
    endtask

    task test_busy_ignore;
        req_valid = 1; req_count = 4'd1;
        step;
        req_count = 4'd5;
        step;
        step;
        n_cmp += 2;
        if (remaining !== 4'd1 || req_ready !== 1'b0) begin n_bad++; $display("FAIL busy_reload: got rem=%0d ready=%b expected 1 0", remaining, req_ready); end
        run(2, 50);
        if (to || dcnt != 1 || dispensed !== 4'd1) begin n_bad++; $display("FAIL busy_result: got done=%0d disp=%0d expected 1 1", dcnt, dispensed); end
    endtask

    task test_back_to_back;
        req_valid = 1; req_count = 4'd2;
        run(2, 50);
        n_cmp += 2;
        if (to || cyc != 15 || rises != 2) begin n_bad++; $display("FAIL b2b_timing: got cyc=%0d rises=%0d expected 15 2", cyc, rises); end
        if (dcnt != 1 || dispensed !== 4'd2) begin n_bad++; $display("FAIL b2b_result: got done=%0d disp=%0d expected 1 2", dcnt, dispensed); end
    endtask

    task test_max;
        req_valid = 1; req_count = 4'd15;
        run(0, 200);
        n_cmp += 2;
        if (to || cyc != 76 || rises != 15) begin n_bad++; $display("FAIL max_timing: got cyc=%0d rises=%0d expected 76 15", cyc, rises); end
        if (dcnt != 1 || dispensed !== 4'd15) begin n_bad++; $display("FAIL max_result: got done=%0d disp=%0d expected 1 15", dcnt, dispensed); end
    endtask

    task test_saturate;
        logic prev, seen;
        s_valid = 1; s_count = 4'd13;
        step;
        s_valid = 0;
        n_cmp += 3;
        if (s_remaining !== 4'd10 || s_drive !== 1'b1) begin n_bad++; $display("FAIL sat_load: got rem=%0d drive=%b expected 10 1", s_remaining, s_drive); end
        rises = 1; prev = 1; seen = 0;
        for (int i = 0; i < 60 && !seen; i++) begin
            step;
            if (s_drive && !prev) rises++;
            prev = s_drive;
            s_coin = s_busy && !s_drive;
            seen = s_done;
        end
        s_coin = 0;
        if (!seen || rises != 10) begin n_bad++; $display("FAIL sat_pulses: got done=%b rises=%0d expected 1 10", seen, rises); end
        if (s_dispensed !== 4'd10 || s_remaining !== 4'd0) begin n_bad++; $display("FAIL sat_counts: got disp=%0d rem=%0d expected 10 0", s_dispensed, s_remaining); end
    endtask

    initial begin
        test_reset;
        test_normal;
        test_timeout;
        test_last_cycle_coin;
        test_span;
        test_reset_mid;
        test_zero;
        test_busy_ignore;
        test_back_to_back;
        test_max;
        test_saturate;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
